// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one combinational 32-bit ALU between two requesters. Each port has
//   a valid/ready handshake and the two are arbitrated round-robin. The ALU
//   result of an accepted op is captured into a one-entry response slot
//   that supports backpressure. Per-port saturating counters record how many
//   ops each port has had accepted.
//
// Ports
//   clk, reset                      clock (rising edge), synchronous active-high reset
//   req{0,1}_valid/ready            request handshake for each port
//   req{0,1}_op/a/b/shamt           request fields (held stable by the requester until ready)
//   alu_op/a/b/shamt                combinational drive to the ALU
//   alu_result, alu_zero            combinational result from the ALU
//   rsp_valid/ready                 response slot handshake
//   rsp_id/result/zero/illegal      registered response contents
//   cnt0, cnt1                      saturating accepted-op counters
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [3:0]        req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [4:0]        req0_shamt,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [3:0]        req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [4:0]        req1_shamt,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [4:0]        alu_shamt,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_illegal,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_t;

    slot_t state;
    slot_t state_next;
    logic  ptr;          // 0: port 0 wins a tie, 1: port 1 wins a tie
    logic  can_accept;
    logic  grant0;
    logic  grant1;
    logic  accept;
    logic  sel;          // port whose fields drive the ALU
    logic  op_illegal;

    assign rsp_valid  = (state == FULL);
    assign can_accept = (state == EMPTY) || rsp_ready;

    // Grant and next-state logic
    always_comb begin
        grant0     = 1'b0;
        grant1     = 1'b0;
        state_next = state;
        if (!reset && can_accept) begin
            if (req0_valid && req1_valid) begin
                grant0 = ~ptr;
                grant1 = ptr;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
        if (grant0 || grant1) begin
            state_next = FULL;
        end else if (rsp_ready) begin
            state_next = EMPTY;
        end
    end

    assign accept     = grant0 | grant1;
    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // With no grant the ALU still sees a port: the one the pointer favours.
    assign sel       = grant1 | (~grant0 & ptr);
    assign alu_op    = sel ? req1_op    : req0_op;
    assign alu_a     = sel ? req1_a     : req0_a;
    assign alu_b     = sel ? req1_b     : req0_b;
    assign alu_shamt = sel ? req1_shamt : req0_shamt;

    always_comb begin
        op_illegal = 1'b1;
        case (alu_op)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
            4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hE: op_illegal = 1'b0;
            default:                            op_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= EMPTY;
            ptr         <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_result  <= '0;
            rsp_zero    <= 1'b0;
            rsp_illegal <= 1'b0;
            cnt0        <= '0;
            cnt1        <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                rsp_result  <= alu_result;
                rsp_zero    <= alu_zero;
                rsp_illegal <= op_illegal;
                rsp_id      <= grant1;
            end
            // Pointer only moves after a contested grant, toward the loser.
            if (req0_valid && req1_valid && accept) begin
                ptr <= grant0;
            end
            if (grant0 && (cnt0 != '1)) begin
                cnt0 <= cnt0 + 1'b1;
            end
            if (grant1 && (cnt1 != '1)) begin
                cnt1 <= cnt1 + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
//   Scoreboard bench: stimulus pushes the hand-computed response of every
//   expected accept; a monitor pops and compares whenever a response is
//   consumed. A second instance with 4-bit counters covers saturation.
module tb_alu_share_arbiter;

    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              req0_valid, req1_valid;
    logic              req0_ready, req1_ready;
    logic [3:0]        req0_op, req1_op;
    logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [4:0]        req0_shamt, req1_shamt;
    logic [3:0]        alu_op;
    logic [DATA_W-1:0] alu_a, alu_b, alu_result;
    logic [4:0]        alu_shamt;
    logic              alu_zero;
    logic              rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_illegal;
    logic [DATA_W-1:0] rsp_result;
    logic [15:0]       cnt0, cnt1;

    // Saturation instance outputs
    logic              s_req0_ready, s_req1_ready;
    logic [3:0]        s_alu_op;
    logic [DATA_W-1:0] s_alu_a, s_alu_b, s_alu_result;
    logic [4:0]        s_alu_shamt;
    logic              s_alu_zero;
    logic              s_rsp_valid, s_rsp_id, s_rsp_zero, s_rsp_illegal;
    logic [DATA_W-1:0] s_rsp_result;
    logic [3:0]        s_cnt0, s_cnt1;

    always #5 clk = ~clk;

    // Reference ALU
    function automatic logic [DATA_W-1:0] alu_f(input logic [3:0] op, input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b, input logic [4:0] sh);
        case (op)
            4'h0: return a & b;
            4'h1: return a | b;
            4'h2: return a ^ b;
            4'h3: return a + b;
            4'h4: return a - b;
            4'h8: return b << sh;
            4'h9: return b >> sh;
            4'hA: return DATA_W'($signed(b) >>> sh);
            4'hB: return {31'd0, $signed(a) < $signed(b)};
            4'hC: return {31'd0, a < b};
            4'hE: return b << 16;
            default: return '0;
        endcase
    endfunction

    assign alu_result   = alu_f(alu_op, alu_a, alu_b, alu_shamt);
    assign alu_zero     = (alu_result == '0);
    assign s_alu_result = alu_f(s_alu_op, s_alu_a, s_alu_b, s_alu_shamt);
    assign s_alu_zero   = (s_alu_result == '0);

    alu_share_arbiter #(.DATA_W(DATA_W), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b), .req0_shamt(req0_shamt),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_shamt(req1_shamt),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    alu_share_arbiter #(.DATA_W(DATA_W), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(s_req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b), .req0_shamt(req0_shamt),
        .req1_valid(req1_valid), .req1_ready(s_req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_shamt(req1_shamt),
        .alu_op(s_alu_op), .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_shamt(s_alu_shamt),
        .alu_result(s_alu_result), .alu_zero(s_alu_zero),
        .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(s_rsp_id),
        .rsp_result(s_rsp_result), .rsp_zero(s_rsp_zero), .rsp_illegal(s_rsp_illegal),
        .cnt0(s_cnt0), .cnt1(s_cnt1)
    );

    typedef struct {
        logic              id;
        logic [DATA_W-1:0] res;
        logic              z;
        logic              ill;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: check the grant at the falling edge, record the expected
    // response (g: 0 none, 1 port 0, 2 port 1), return just after the rising edge.
    task automatic tick(input int g, input logic [DATA_W-1:0] er, input logic ez, input logic ei);
        exp_t e;
        @(negedge clk);
        chk("req0_ready", {31'd0, req0_ready}, {31'd0, g == 1});
        chk("req1_ready", {31'd0, req1_ready}, {31'd0, g == 2});
        if (g != 0) begin
            e.id  = (g == 2);
            e.res = er;
            e.z   = ez;
            e.ill = ei;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: a response is consumed at the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
                chk("rsp_result", rsp_result, e.res);
                chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, e.z});
                chk("rsp_illegal", {31'd0, rsp_illegal}, {31'd0, e.ill});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;  rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 4'h3; req0_a = 32'd1; req0_b = 32'd1; req0_shamt = 5'd0;
        req1_valid = 1'b1; req1_op = 4'h3; req1_a = 32'd1; req1_b = 32'd1; req1_shamt = 5'd0;

        // Reset: no grant while reset is high, outputs cleared
        tick(0, '0, 0, 0);
        tick(0, '0, 0, 0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        chk("rst_rsp_zero", {31'd0, rsp_zero}, 32'd0);
        chk("rst_rsp_illegal", {31'd0, rsp_illegal}, 32'd0);
        chk("rst_cnt0", {16'd0, cnt0}, 32'd0);
        chk("rst_cnt1", {16'd0, cnt1}, 32'd0);
        reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;

        // Single request: ADD 5+7
        req0_valid = 1'b1; req0_op = 4'h3; req0_a = 32'd5; req0_b = 32'd7;
        tick(1, 32'd12, 0, 0);
        req0_valid = 1'b0;
        chk("single_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("single_cnt0", {16'd0, cnt0}, 32'd1);
        tick(0, '0, 0, 0);
        chk("drain_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("drain_hold_result", rsp_result, 32'd12);

        // Contention: SUB 9-9 on port 0, SLL 1<<4 on port 1
        req0_valid = 1'b1; req0_op = 4'h4; req0_a = 32'd9; req0_b = 32'd9; req0_shamt = 5'd0;
        req1_valid = 1'b1; req1_op = 4'h8; req1_a = 32'd0; req1_b = 32'd1; req1_shamt = 5'd4;
        tick(1, 32'd0, 1, 0);
        tick(2, 32'd16, 0, 0);
        tick(1, 32'd0, 1, 0);
        tick(2, 32'd16, 0, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("cont_cnt0", {16'd0, cnt0}, 32'd3);
        chk("cont_cnt1", {16'd0, cnt1}, 32'd2);
        tick(0, '0, 0, 0);

        // Backpressure: slot full, port 1 waiting
        req1_valid = 1'b1; req1_op = 4'h3; req1_a = 32'd1; req1_b = 32'd1;
        tick(2, 32'd2, 0, 0);
        rsp_ready = 1'b0; req1_a = 32'd100; req1_b = 32'd23;
        for (int i = 0; i < 5; i++) begin
            tick(0, '0, 0, 0);
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rsp_result", rsp_result, 32'd2);
            chk("bp_rsp_id", {31'd0, rsp_id}, 32'd1);
        end
        rsp_ready = 1'b1;
        tick(2, 32'd123, 0, 0);
        chk("bp_refill_valid", {31'd0, rsp_valid}, 32'd1);
        req1_valid = 1'b0;
        tick(0, '0, 0, 0);

        // Illegal op, then LUI
        req0_valid = 1'b1; req0_op = 4'h5; req0_a = 32'd1; req0_b = 32'd2;
        tick(1, 32'd0, 1, 1);
        req0_op = 4'hE; req0_a = 32'd0; req0_b = 32'h1234;
        tick(1, 32'h1234_0000, 0, 0);
        req0_valid = 1'b0;
        tick(0, '0, 0, 0);

        // Reset mid-op: pointer set to 1 first, response pending
        req0_valid = 1'b1; req0_op = 4'h3; req0_a = 32'd2; req0_b = 32'd3;
        req1_valid = 1'b1; req1_op = 4'h4; req1_a = 32'd10; req1_b = 32'd3; req1_shamt = 5'd0;
        tick(1, 32'd5, 0, 0);
        rsp_ready = 1'b0;
        reset = 1'b1;
        tick(0, '0, 0, 0);
        reset = 1'b0;
        chk("rstmid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rstmid_cnt0", {16'd0, cnt0}, 32'd0);
        chk("rstmid_cnt1", {16'd0, cnt1}, 32'd0);
        sb.delete();
        rsp_ready = 1'b1;
        tick(1, 32'd5, 0, 0);
        tick(2, 32'd7, 0, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick(0, '0, 0, 0);

        // Saturation on the 4-bit-counter instance
        reset = 1'b1;
        tick(0, '0, 0, 0);
        reset = 1'b0;
        req0_valid = 1'b1; req0_op = 4'h3; req0_b = 32'd0;
        for (int i = 1; i <= 20; i++) begin
            req0_a = i;
            tick(1, i, 0, 0);
            if (i == 15) chk("sat_cnt0_at15", {28'd0, s_cnt0}, 32'd15);
        end
        req0_valid = 1'b0;
        chk("sat_cnt0", {28'd0, s_cnt0}, 32'd15);
        chk("sat_cnt1", {28'd0, s_cnt1}, 32'd0);
        chk("wide_cnt0", {16'd0, cnt0}, 32'd20);
        tick(0, '0, 0, 0);
        tick(0, '0, 0, 0);
        chk("sb_empty", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
